// File: rtl/dmem_pkg.sv
// Shared types, size codes and the alignment/legality check for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned sizes only make sense for loads, so a store using them is rejected.
  function automatic logic misaligned(input logic [2:0] funct3, input logic we,
                                      input logic [1:0] addr_lo);
    logic r_bad;
    case (funct3)
      F3_B:    r_bad = 1'b0;
      F3_H:    r_bad = addr_lo[0];
      F3_W:    r_bad = |addr_lo;
      F3_BU:   r_bad = we;
      F3_HU:   r_bad = we | addr_lo[0];
      default: r_bad = 1'b1;
    endcase
    return r_bad;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin grant: the port that did not win last time wins a tie.
// Purely combinational; grant is zero when no port is valid.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the data memory: accept -> ACCESS -> RESP, response two cycles after accept.
// Ready is only offered in IDLE (one request per 3 cycles); grant counters exist with DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [5:0]              req_funct3,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              rsp_valid,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    mem_wen,
  output logic [2:0]              mem_funct3,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]    grant_cnt0,
  output logic [CNT_WIDTH-1:0]    grant_cnt1,
  output logic [CNT_WIDTH-1:0]    conflict_cnt
`endif
);

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_last_grant;
  logic                    r_owner;
  logic                    r_we;
  logic                    r_err;
  logic [2:0]              r_funct3;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_rdata;

  logic [1:0]              w_grant;
  logic [1:0]              w_ready;
  logic                    w_hs;
  logic                    w_sel;
  logic                    w_sel_we;
  logic [2:0]              w_sel_funct3;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;

  rr_arb2 u_rr_arb2 (
    .i_valid      (req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_ready      = (r_state == IDLE) ? w_grant : 2'b00;
  assign w_hs         = |(req_valid & w_ready);
  assign w_sel        = w_grant[1];
  assign w_sel_we     = w_sel ? req_we[1] : req_we[0];
  assign w_sel_funct3 = w_sel ? req_funct3[5:3] : req_funct3[2:0];
  assign w_sel_addr   = w_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign w_sel_wdata  = w_sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_owner      <= w_sel;
        r_last_grant <= w_sel;
        r_we         <= w_sel_we;
        r_err        <= misaligned(w_sel_funct3, w_sel_we, w_sel_addr[1:0]);
        r_funct3     <= w_sel_funct3;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
      end
      // Stores and rejected requests return zero rather than whatever the memory drives.
      if (r_state == ACCESS) begin
        r_rdata <= (r_we || r_err) ? '0 : mem_rdata;
      end
    end
  end

  assign req_ready  = w_ready;
  assign mem_wen    = (r_state == ACCESS) && r_we && !r_err;
  assign mem_funct3 = r_funct3;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign rsp_valid  = (r_state == RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_err    = (r_state == RESP) && r_err;
  assign rsp_rdata  = r_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] r_grant_cnt0;
  logic [CNT_WIDTH-1:0] r_grant_cnt1;
  logic [CNT_WIDTH-1:0] r_conflict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt0   <= '0;
      r_grant_cnt1   <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_hs && !w_sel && !(&r_grant_cnt0)) r_grant_cnt0 <= r_grant_cnt0 + 1'b1;
      if (w_hs && w_sel && !(&r_grant_cnt1))  r_grant_cnt1 <= r_grant_cnt1 + 1'b1;
      if ((r_state == IDLE) && (&req_valid) && !(&r_conflict_cnt))
        r_conflict_cnt <= r_conflict_cnt + 1'b1;
    end
  end

  assign grant_cnt0   = r_grant_cnt0;
  assign grant_cnt1   = r_grant_cnt1;
  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table of single transactions plus reset and conflict sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [5:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_wen;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
  logic [15:0] conflict_cnt;
`endif

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .mem_wen    (mem_wen),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1),
    .conflict_cnt (conflict_cnt)
`endif
  );

  // Little-endian byte memory, combinational read with sign/zero extension.
  logic [7:0] mem [0:63];

  always_comb begin
    logic [5:0] a;
    a = mem_addr[5:0];
    mem_rdata = 32'h0;
    case (mem_funct3)
      3'b000: mem_rdata = {{24{mem[a][7]}}, mem[a]};
      3'b001: mem_rdata = {{16{mem[a+6'd1][7]}}, mem[a+6'd1], mem[a]};
      3'b010: mem_rdata = {mem[a+6'd3], mem[a+6'd2], mem[a+6'd1], mem[a]};
      3'b100: mem_rdata = {24'h0, mem[a]};
      3'b101: mem_rdata = {16'h0, mem[a+6'd1], mem[a]};
      default: mem_rdata = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_wen) begin
      mem[mem_addr[5:0]] <= mem_wdata[7:0];
      if (mem_funct3[1:0] != 2'b00) mem[mem_addr[5:0]+6'd1] <= mem_wdata[15:8];
      if (mem_funct3[1:0] == 2'b10) begin
        mem[mem_addr[5:0]+6'd2] <= mem_wdata[23:16];
        mem[mem_addr[5:0]+6'd3] <= mem_wdata[31:24];
      end
    end
  end

  int cyc = 0;
  int wen_cnt = 0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (mem_wen === 1'b1) wen_cnt++;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_wen;
  } vec_t;

  vec_t tbl [15];

  task automatic wait_ready(input string nm);
    int w = 0;
    while (req_ready == 2'b00 && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 8) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no ready expected ready within 8 cycles", nm);
    end
  endtask

  task automatic do_req(input vec_t v, input string nm);
    int start;
    start = wen_cnt;
    req_we[v.port]             = v.we;
    req_funct3[v.port*3 +: 3]  = v.f3;
    req_addr[v.port*32 +: 32]  = v.addr;
    req_wdata[v.port*32 +: 32] = v.wdata;
    req_valid = 2'b01 << v.port;
    #1;
    wait_ready(nm);
    check({nm, "_ready"}, {30'h0, req_ready}, {30'h0, 2'b01 << v.port});
    @(posedge clk); #1;
    // Scramble the requester after the handshake; the latched copy must be used.
    req_valid = 2'b00;
    req_addr  = {2{32'hFFFF_FFF3}};
    req_wdata = {2{32'h0BAD_0BAD}};
    req_we    = 2'b11;
    check({nm, "_addr"}, mem_addr, v.addr);
    check({nm, "_wen"}, {31'h0, mem_wen}, v.exp_wen);
    @(posedge clk); #1;
    check({nm, "_rspv"}, {30'h0, rsp_valid}, {30'h0, 2'b01 << v.port});
    check({nm, "_err"}, {31'h0, rsp_err}, {31'h0, v.exp_err});
    check({nm, "_rdata"}, rsp_rdata, v.exp_rdata);
    @(posedge clk); #1;
    check({nm, "_rspv_off"}, {30'h0, rsp_valid}, 32'h0);
    check({nm, "_wen_cycles"}, wen_cnt - start, v.exp_wen);
    req_we = 2'b00;
  endtask

  initial begin
    int n0;
    int n1;
    int prev_hs;
    int hs;
    logic [1:0] exp_g;

    tbl[0]  = '{1'b0, 1'b1, 3'b010, 32'h0001_0000, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1};
    tbl[1]  = '{1'b0, 1'b0, 3'b010, 32'h0001_0000, 32'h0,        1'b0, 32'hDEAD_BEEF, 0};
    tbl[2]  = '{1'b1, 1'b1, 3'b001, 32'h0001_0001, 32'h0000_5555, 1'b1, 32'h0000_0000, 0};
    tbl[3]  = '{1'b1, 1'b0, 3'b010, 32'h0001_0000, 32'h0,        1'b0, 32'hDEAD_BEEF, 0};
    tbl[4]  = '{1'b0, 1'b1, 3'b000, 32'h0001_0004, 32'hFFFF_FF80, 1'b0, 32'h0000_0000, 1};
    tbl[5]  = '{1'b0, 1'b0, 3'b000, 32'h0001_0004, 32'h0,        1'b0, 32'hFFFF_FF80, 0};
    tbl[6]  = '{1'b0, 1'b0, 3'b100, 32'h0001_0004, 32'h0,        1'b0, 32'h0000_0080, 0};
    tbl[7]  = '{1'b1, 1'b0, 3'b001, 32'h0001_0002, 32'h0,        1'b0, 32'hFFFF_DEAD, 0};
    tbl[8]  = '{1'b1, 1'b0, 3'b101, 32'h0001_0002, 32'h0,        1'b0, 32'h0000_DEAD, 0};
    tbl[9]  = '{1'b0, 1'b0, 3'b010, 32'h0001_0002, 32'h0,        1'b1, 32'h0000_0000, 0};
    tbl[10] = '{1'b0, 1'b0, 3'b011, 32'h0001_0000, 32'h0,        1'b1, 32'h0000_0000, 0};
    tbl[11] = '{1'b1, 1'b1, 3'b100, 32'h0001_0000, 32'h0,        1'b1, 32'h0000_0000, 0};
    tbl[12] = '{1'b1, 1'b0, 3'b010, 32'h0001_0000, 32'h0,        1'b0, 32'hDEAD_BEEF, 0};
    tbl[13] = '{1'b0, 1'b1, 3'b001, 32'h0001_0006, 32'h1234_ABCD, 1'b0, 32'h0000_0000, 1};
    tbl[14] = '{1'b1, 1'b0, 3'b010, 32'h0001_0004, 32'h0,        1'b0, 32'hABCD_0080, 0};

    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    rst_n      = 1'b0;
    req_valid  = 2'b00;
    req_we     = 2'b00;
    req_funct3 = 6'h0;
    req_addr   = 64'h0;
    req_wdata  = 64'h0;
    #12;
    check("rst_ready", {30'h0, req_ready}, 32'h0);
    check("rst_rspv", {30'h0, rsp_valid}, 32'h0);
    check("rst_err", {31'h0, rsp_err}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_wen", {31'h0, mem_wen}, 32'h0);
    check("rst_maddr", mem_addr, 32'h0);
    check("rst_mwdata", mem_wdata, 32'h0);
    check("rst_mf3", {29'h0, mem_funct3}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 15; i++) begin
      do_req(tbl[i], $sformatf("vec%0d", i));
      if (tbl[i].port) n1++; else n0++;
    end
`ifdef DMEM_ARB_STATS_EN
    check("stats_g0", {16'h0, grant_cnt0}, n0);
    check("stats_g1", {16'h0, grant_cnt1}, n1);
    check("stats_conf0", {16'h0, conflict_cnt}, 32'h0);
`endif

    // Reset lands in the ACCESS cycle of a store: the write must never happen.
    req_we[0]        = 1'b1;
    req_funct3[2:0]  = 3'b010;
    req_addr[31:0]   = 32'h0001_0008;
    req_wdata[31:0]  = 32'h1122_3344;
    req_valid        = 2'b01;
    #1;
    wait_ready("rstmid");
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("rstmid_wen_before", {31'h0, mem_wen}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_wen_async", {31'h0, mem_wen}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rstmid_rspv%0d", i), {30'h0, rsp_valid}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstmid_rspv_after", {30'h0, rsp_valid}, 32'h0);

    // Both ports request continuously: port 0 first after reset, then strict alternation.
    req_we          = 2'b00;
    req_funct3      = {3'b010, 3'b010};
    req_addr        = {32'h0001_0008, 32'h0001_0000};
    req_valid       = 2'b11;
    #1;
    prev_hs = 0;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_ready($sformatf("conf%0d", i));
      check($sformatf("conf%0d_grant", i), {30'h0, req_ready}, {30'h0, exp_g});
      @(posedge clk); #1;
      hs = cyc;
      if (i == 5) req_valid = 2'b00;
      if (i > 0) check($sformatf("conf%0d_gap", i), hs - prev_hs, 32'd3);
      prev_hs = hs;
      @(posedge clk); #1;
      check($sformatf("conf%0d_rspv", i), {30'h0, rsp_valid}, {30'h0, exp_g});
      check($sformatf("conf%0d_rdata", i), rsp_rdata,
            (i % 2 == 0) ? 32'hDEAD_BEEF : 32'h0000_0000);
      @(posedge clk); #1;
    end
`ifdef DMEM_ARB_STATS_EN
    check("stats_g0_post", {16'h0, grant_cnt0}, 32'd3);
    check("stats_g1_post", {16'h0, grant_cnt1}, 32'd3);
    check("stats_conf", {16'h0, conflict_cnt}, 32'd6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
